// File: rtl/exu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : exu_arbiter
// Description : Two-requester round-robin arbiter and sequencer for the shared
//               combinational RV32 ALU. It accepts one operation at a time,
//               holds the operands on the ALU for ALU_WAIT cycles, captures the
//               result and returns it on a single tagged response channel.
//               Optional build macro EXU_ARB_ILLEGAL_CHK_EN enables the
//               illegal func/auxFunc check, which answers with rsp_err=1 and
//               skips the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module exu_arbiter #(
    parameter int ALU_WAIT = 1   // operand settle cycles, 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    // requester 0
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [31:0] r0_opA,
    input  logic [31:0] r0_opB,
    input  logic [2:0]  r0_func,
    input  logic [6:0]  r0_auxFunc,
    // requester 1
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [31:0] r1_opA,
    input  logic [31:0] r1_opB,
    input  logic [2:0]  r1_func,
    input  logic [6:0]  r1_auxFunc,
    // ExecutionUnit side
    output logic [31:0] alu_opA,
    output logic [31:0] alu_opB,
    output logic [2:0]  alu_func,
    output logic [6:0]  alu_auxFunc,
    input  logic [31:0] alu_out,
    // response channel
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    localparam logic [3:0] c_WAIT_LOAD = 4'(ALU_WAIT - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_last_grant;
    logic [31:0] r_opa;
    logic [31:0] r_opb;
    logic [2:0]  r_func;
    logic [6:0]  r_aux;
    logic        r_id;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;

    logic        w_in_idle;
    logic        w_grant_id;
    logic        w_accept;
    logic [31:0] w_sel_opa;
    logic [31:0] w_sel_opb;
    logic [2:0]  w_sel_func;
    logic [6:0]  w_sel_aux;

    // Grant selection: a lone requester wins; under contention the one that
    // was not served last wins.
    assign w_in_idle  = (r_state == c_IDLE);
    assign w_grant_id = (r0_valid & r1_valid) ? ~r_last_grant : r1_valid;
    assign r0_ready   = w_in_idle & r0_valid & ~w_grant_id;
    assign r1_ready   = w_in_idle & r1_valid &  w_grant_id;
    assign w_accept   = r0_ready | r1_ready;

    assign w_sel_opa  = w_grant_id ? r1_opA     : r0_opA;
    assign w_sel_opb  = w_grant_id ? r1_opB     : r0_opB;
    assign w_sel_func = w_grant_id ? r1_func    : r0_func;
    assign w_sel_aux  = w_grant_id ? r1_auxFunc : r0_auxFunc;

    // The ALU sees the latched operation directly, so its inputs only move
    // on an accept and stay put through EXEC, RESP and IDLE.
    assign alu_opA     = r_opa;
    assign alu_opB     = r_opb;
    assign alu_func    = r_func;
    assign alu_auxFunc = r_aux;

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_id;
    assign rsp_data  = r_rsp_data;

`ifdef EXU_ARB_ILLEGAL_CHK_EN
    logic w_legal;
    logic r_rsp_err;

    // Legal set: base ops with auxFunc zero, plus SUB/SRA with bit 5 set.
    assign w_legal = (w_sel_aux == 7'b0000000) |
                     ((w_sel_aux == 7'b0100000) &
                      ((w_sel_func == 3'b000) | (w_sel_func == 3'b101)));
    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    // Latch the accepted operation and its requester tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opa  <= 32'd0;
            r_opb  <= 32'd0;
            r_func <= 3'd0;
            r_aux  <= 7'd0;
            r_id   <= 1'b0;
        end else if (w_accept) begin
            r_opa  <= w_sel_opa;
            r_opb  <= w_sel_opb;
            r_func <= w_sel_func;
            r_aux  <= w_sel_aux;
            r_id   <= w_grant_id;
        end
    end

    // Sequencer: IDLE accepts, EXEC counts down the settle time, RESP holds
    // the result until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_cnt        <= 4'd0;
            r_last_grant <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= 32'd0;
`ifdef EXU_ARB_ILLEGAL_CHK_EN
            r_rsp_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
`ifdef EXU_ARB_ILLEGAL_CHK_EN
                        if (!w_legal) begin
                            r_rsp_data  <= 32'd0;
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= c_RESP;
                        end else begin
                            r_rsp_err   <= 1'b0;
                            r_cnt       <= c_WAIT_LOAD;
                            r_state     <= c_EXEC;
                        end
`else
                        r_cnt   <= c_WAIT_LOAD;
                        r_state <= c_EXEC;
`endif
                    end
                end
                c_EXEC: begin
                    if (r_cnt == 4'd0) begin
                        r_rsp_data  <= alu_out;
                        r_rsp_valid <= 1'b1;
                        r_state     <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_RESP: begin
                    if (rsp_ready) begin
                        r_last_grant <= r_id;
                        r_rsp_valid  <= 1'b0;
                        r_state      <= c_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_exu_arbiter
// Description : Directed self-checking bench for exu_arbiter, with a small
//               RV32 ALU stand-in driving alu_out. Runs with ALU_WAIT=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exu_arbiter;

    localparam int W = 3;

    logic        clk;
    logic        rst_n;
    logic        r0_valid, r0_ready;
    logic [31:0] r0_opA, r0_opB;
    logic [2:0]  r0_func;
    logic [6:0]  r0_auxFunc;
    logic        r1_valid, r1_ready;
    logic [31:0] r1_opA, r1_opB;
    logic [2:0]  r1_func;
    logic [6:0]  r1_auxFunc;
    logic [31:0] alu_opA, alu_opB, alu_out;
    logic [2:0]  alu_func;
    logic [6:0]  alu_auxFunc;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_data;

    int n_checks = 0;
    int n_fail   = 0;

    exu_arbiter #(.ALU_WAIT(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_opA(r0_opA),
        .r0_opB(r0_opB), .r0_func(r0_func), .r0_auxFunc(r0_auxFunc),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_opA(r1_opA),
        .r1_opB(r1_opB), .r1_func(r1_func), .r1_auxFunc(r1_auxFunc),
        .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_func(alu_func),
        .alu_auxFunc(alu_auxFunc), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the ExecutionUnit: unsupported pairs return 0.
    function automatic logic [31:0] alu_model(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [2:0] f,
                                              input logic [6:0] x);
        logic [31:0] res;
        res = 32'd0;
        if (x == 7'b0000000) begin
            case (f)
                3'b000: res = a + b;
                3'b001: res = a << b[4:0];
                3'b010: res = {31'd0, $signed(a) < $signed(b)};
                3'b011: res = {31'd0, a < b};
                3'b100: res = a ^ b;
                3'b101: res = a >> b[4:0];
                3'b110: res = a | b;
                default: res = a & b;
            endcase
        end else if (x == 7'b0100000) begin
            if (f == 3'b000)      res = a - b;
            else if (f == 3'b101) res = $unsigned($signed(a) >>> b[4:0]);
        end
        return res;
    endfunction

    assign alu_out = alu_model(alu_opA, alu_opB, alu_func, alu_auxFunc);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until rsp_valid is seen; cyc is the number of edges waited.
    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 50) begin
            tick();
            cyc++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b0;
        r0_opA = 0; r0_opB = 0; r0_func = 0; r0_auxFunc = 0;
        r1_opA = 0; r1_opB = 0; r1_func = 0; r1_auxFunc = 0;
        #2;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_data, alu_opA, alu_opB, alu_func, alu_auxFunc} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rsp_valid=%b id=%b err=%b data=%h aluA=%h aluB=%h f=%h x=%h, required all 0",
                     rsp_valid, rsp_id, rsp_err, rsp_data, alu_opA, alu_opB, alu_func, alu_auxFunc);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({r0_ready, r1_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle_ready: got %b%b, required 00", r0_ready, r1_ready);
        end
    endtask

    task automatic test_single_add();
        int cyc;
        rsp_ready = 1'b1;
        r0_opA = 32'd5; r0_opB = 32'd7; r0_func = 3'b000; r0_auxFunc = 7'd0;
        r0_valid = 1'b1;
        #1;
        n_checks++;
        if ({r0_ready, r1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL add_ready: got r0=%b r1=%b, required r0=1 r1=0", r0_ready, r1_ready);
        end
        tick();
        r0_valid = 1'b0;
        n_checks++;
        if (r0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL add_ready_pulse: got %b, required 0", r0_ready);
        end
        wait_rsp(cyc);
        n_checks++;
        if (cyc != W || rsp_id !== 1'b0 || rsp_data !== 32'd12 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL add_rsp: cyc=%0d id=%b data=%h err=%b, required cyc=%0d id=0 data=0000000c err=0",
                     cyc, rsp_id, rsp_data, rsp_err, W);
        end
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_rsp_drop: rsp_valid=%b, required 0", rsp_valid);
        end
    endtask

    task automatic test_contention();
        int cyc;
        do_reset();
        rsp_ready = 1'b1;
        r0_opA = 32'd10; r0_opB = 32'd3; r0_func = 3'b000; r0_auxFunc = 7'b0100000;
        r1_opA = 32'h8000_0000; r1_opB = 32'd4; r1_func = 3'b101; r1_auxFunc = 7'b0100000;
        r0_valid = 1'b1; r1_valid = 1'b1;
        #1;
        n_checks++;
        if ({r0_ready, r1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL cont_grant0: got r0=%b r1=%b, required r0=1 r1=0", r0_ready, r1_ready);
        end
        tick();
        wait_rsp(cyc);
        n_checks++;
        if (cyc != W || rsp_id !== 1'b0 || rsp_data !== 32'd7) begin
            n_fail++;
            $display("FAIL cont_rsp0: cyc=%0d id=%b data=%h, required cyc=%0d id=0 data=00000007",
                     cyc, rsp_id, rsp_data, W);
        end
        tick();
        n_checks++;
        if ({r0_ready, r1_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL cont_grant1: got r0=%b r1=%b, required r0=0 r1=1", r0_ready, r1_ready);
        end
        tick();
        wait_rsp(cyc);
        n_checks++;
        if (cyc != W || rsp_id !== 1'b1 || rsp_data !== 32'hF800_0000) begin
            n_fail++;
            $display("FAIL cont_rsp1: cyc=%0d id=%b data=%h, required cyc=%0d id=1 data=f8000000",
                     cyc, rsp_id, rsp_data, W);
        end
        tick();
        n_checks++;
        if ({r0_ready, r1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL cont_grant_alt: got r0=%b r1=%b, required r0=1 r1=0", r0_ready, r1_ready);
        end
        // r1 drops out; r0 should then be served back-to-back.
        r1_valid = 1'b0;
        r0_opA = 32'h0000_00F0; r0_opB = 32'h0000_0F0F; r0_func = 3'b110; r0_auxFunc = 7'd0;
        tick();
        wait_rsp(cyc);
        tick();
        n_checks++;
        if (r0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lone_back_to_back: r0_ready=%b, required 1", r0_ready);
        end
        tick();
        r0_valid = 1'b0;
        wait_rsp(cyc);
        n_checks++;
        if (rsp_id !== 1'b0 || rsp_data !== 32'h0000_0FFF) begin
            n_fail++;
            $display("FAIL lone_rsp: id=%b data=%h, required id=0 data=00000fff", rsp_id, rsp_data);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int cyc;
        rsp_ready = 1'b0;
        r0_opA = 32'hFFFF_00FF; r0_opB = 32'h0F0F_0F0F; r0_func = 3'b111; r0_auxFunc = 7'd0;
        r1_opA = 32'h1234_5678; r1_opB = 32'd4; r1_func = 3'b001; r1_auxFunc = 7'd0;
        r0_valid = 1'b1;
        tick();
        r0_valid = 1'b0;
        r1_valid = 1'b1;
        wait_rsp(cyc);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'h0F0F_000F || r1_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%b id=%b data=%h r1_ready=%b, required 1 0 0f0f000f 0",
                         i, rsp_valid, rsp_id, rsp_data, r1_ready);
            end
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (r1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_in_resp: r1_ready=%b, required 0", r1_ready);
        end
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0 || r1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: rsp_valid=%b r1_ready=%b, required 0 1", rsp_valid, r1_ready);
        end
        tick();
        r1_valid = 1'b0;
        wait_rsp(cyc);
        n_checks++;
        if (cyc != W || rsp_id !== 1'b1 || rsp_data !== 32'h2345_6780) begin
            n_fail++;
            $display("FAIL bp_r1_rsp: cyc=%0d id=%b data=%h, required cyc=%0d id=1 data=23456780",
                     cyc, rsp_id, rsp_data, W);
        end
        tick();
    endtask

    task automatic test_sltu_stable();
        int cyc;
        rsp_ready = 1'b1;
        r0_opA = 32'd1; r0_opB = 32'hFFFF_FFFF; r0_func = 3'b011; r0_auxFunc = 7'd0;
        r0_valid = 1'b1;
        tick();
        r0_valid = 1'b0;
        r0_opA = 32'hDEAD_BEEF; r0_opB = 32'd0; r0_func = 3'b100;
        cyc = 0;
        for (int i = 0; i < W; i++) begin
            n_checks++;
            if (alu_opA !== 32'd1 || alu_opB !== 32'hFFFF_FFFF || alu_func !== 3'b011 ||
                alu_auxFunc !== 7'd0 || rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL sltu_hold[%0d]: A=%h B=%h f=%h x=%h valid=%b, required 00000001 ffffffff 3 00 0",
                         i, alu_opA, alu_opB, alu_func, alu_auxFunc, rsp_valid);
            end
            tick();
            cyc++;
        end
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'd1) begin
            n_fail++;
            $display("FAIL sltu_rsp: valid=%b data=%h after %0d edges, required 1 00000001", rsp_valid, rsp_data, cyc);
        end
        tick();
    endtask

    task automatic test_reset_mid_exec();
        rsp_ready = 1'b1;
        r1_opA = 32'd100; r1_opB = 32'd1; r1_func = 3'b000; r1_auxFunc = 7'd0;
        r1_valid = 1'b1;
        tick();
        r1_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_err, alu_opA, alu_opB, alu_func, alu_auxFunc} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: valid=%b data=%h id=%b A=%h B=%h, required all 0",
                     rsp_valid, rsp_data, rsp_id, alu_opA, alu_opB);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < W + 3; i++) begin
            tick();
            n_checks++;
            if (rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_no_rsp[%0d]: rsp_valid=%b, required 0", i, rsp_valid);
            end
        end
        r0_opA = 32'd1; r0_opB = 32'd1; r0_func = 3'b000; r0_auxFunc = 7'd0;
        r0_valid = 1'b1; r1_valid = 1'b1;
        #1;
        n_checks++;
        if ({r0_ready, r1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL midrst_grant: got r0=%b r1=%b, required r0=1 r1=0", r0_ready, r1_ready);
        end
        do_reset();
    endtask

    task automatic test_illegal();
        int cyc;
        rsp_ready = 1'b1;
        r1_opA = 32'd9; r1_opB = 32'd2; r1_func = 3'b001; r1_auxFunc = 7'b0100000;
        r1_valid = 1'b1;
        tick();
        r1_valid = 1'b0;
        wait_rsp(cyc);
`ifdef EXU_ARB_ILLEGAL_CHK_EN
        n_checks++;
        if (cyc != 0 || rsp_err !== 1'b1 || rsp_data !== 32'd0 || rsp_id !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_rsp: cyc=%0d err=%b data=%h id=%b, required 0 1 00000000 1",
                     cyc, rsp_err, rsp_data, rsp_id);
        end
`else
        n_checks++;
        if (cyc != W || rsp_err !== 1'b0 || rsp_data !== 32'd0 || rsp_id !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_rsp: cyc=%0d err=%b data=%h id=%b, required %0d 0 00000000 1",
                     cyc, rsp_err, rsp_data, rsp_id, W);
        end
`endif
        tick();
        // A legal op right after must report no error.
        r0_opA = 32'd4; r0_opB = 32'd9; r0_func = 3'b010; r0_auxFunc = 7'd0;
        r0_valid = 1'b1;
        tick();
        r0_valid = 1'b0;
        wait_rsp(cyc);
        n_checks++;
        if (cyc != W || rsp_err !== 1'b0 || rsp_data !== 32'd1) begin
            n_fail++;
            $display("FAIL legal_after_illegal: cyc=%0d err=%b data=%h, required %0d 0 00000001",
                     cyc, rsp_err, rsp_data, W);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_contention();
        test_backpressure();
        test_sltu_stable();
        test_reset_mid_exec();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
